seg7_scan_controller: RTL and testbench
=======================================

// Module: seg7_scan_controller
// PURPOSE
//  Time-multiplexes one BCD-to-7-segment decoder across DIGITS common-anode digit positions.
//  Sits between the control logic, which supplies packed BCD digit values, and the board's shared segment bus and digit enables.
//  Display updates are double-buffered and take effect only at frame boundaries, so a digit is never shown half-updated.
// PARAMETERS
//  DIGITS  4      number of digit positions scanned (2..8)
//  DWELL   50000  clocks each digit is lit per scan slot (>=1)
//  GAP     16     clocks all digits are off between slots (anti-ghosting, >=1)
// PORTS
//  i_Clk     in   1           system clock; single clock domain
//  i_Rst     in   1           reset, asynchronous, active-high
//  i_En      in   1           scan enable; low = display dark
//  i_Load    in   1           load strobe for i_Digits; honoured only while o_Ready=1
//  i_Digits  in   4*DIGITS    packed BCD values, digit k = [4k+3:4k], digit 0 = rightmost
//  o_Ready   out  1           1 = pending buffer free, a new i_Load is accepted
//  o_Seg     out  7           segment pattern {g,f,e,d,c,b,a}, active-high
//  o_Dig     out  DIGITS      digit enables, active-low, at most one bit low
//  o_Frame   out  1           1-cycle pulse when the last digit's slot ends
// BEHAVIOUR
//  Reset values: o_Seg=0, o_Dig=all 1, o_Ready=1, o_Frame=0; index=0; state S_GAP; counter=0; display and pending buffers=0.
//  FSM states:
//   S_GAP: all digits off; counts GAP cycles, then goes to S_SHOW.
//   S_SHOW: o_Dig[index]=0; counts DWELL cycles, then goes to S_GAP with index=index+1 mod DIGITS.
//   Wrap DIGITS-1 -> 0: o_Frame pulses for 1 cycle (frame boundary).
//  Output timing: o_Seg and o_Dig are registered and change on the same edge.
//   Decoder input = display buffer nibble [index]; its output is registered alongside o_Dig.
//   While o_Dig is all 1, o_Seg is 0.
//  Load handshake:
//   i_Load & o_Ready -> i_Digits captured into the pending buffer; o_Ready=0 next cycle.
//   At the next frame boundary: pending -> display buffer; o_Ready=1 on the following cycle.
//   i_Load while o_Ready=0 is ignored; the pending contents are not overwritten.
//   A load accepted in the same cycle as a frame boundary is applied at the following boundary, not the current one.
//  Digit values 10..15: decode to the "0" pattern (7'h3f), identical to the shared decoder's default.
//  i_En=0: next cycle state=S_GAP, index=0, counter=0, o_Dig=all 1, o_Seg=0, no o_Frame.
//   Any pending load is applied to the display buffer one cycle after i_En falls (treated as a frame boundary; no pulse).
//  i_En rising: scan restarts at digit 0 after a full GAP.
//  Reset asserted mid-operation: immediate return to reset values; a pending load is discarded.
//  Counter width: $clog2(max(DWELL,GAP)+1). Terminal counts: DWELL-1 and GAP-1, so the slot period is exactly DWELL+GAP cycles.
// CONFIGURATION
//  SEG7_LZB_EN defined:
//   Leading-zero blanking; a digit k>0 is blanked when it and every higher digit hold 0.
//   A blanked slot keeps its full timing but o_Dig stays all 1 and o_Seg=0.
//   Digit 0 is never blanked.
//  SEG7_LZB_EN undefined: every digit is shown, zeros included.
// STRUCTURE
//  Package seg7_pkg:
//   scan state enum {S_GAP, S_SHOW}
//   SEG_OFF=7'h00, SEG_ZERO=7'h3f
//   BCD nibble typedef
//  Sub-module: one instance of the team's Binary_To_7Segment decoder, fed by the selected display nibble.
//   There is no per-digit decoder.
//  All other logic (FSM, counter, index, buffers, handshake) is flat in this module.
// TESTING (bench params DIGITS=4, DWELL=8, GAP=2)
//  1. Reset, i_En=1, load 16'h4321:
//     o_Dig cycles 1110->1101->1011->0111; o_Seg=06,5b,4f,66.
//     Each digit is lit 8 cycles, with 2 dark cycles between; o_Frame period = 40 cycles.
//  2. Load 16'h9999 mid-frame:
//     o_Ready=0 until the boundary; the current frame still shows the old values; the next frame shows 6f on all digits.
//  3. Second i_Load while o_Ready=0 (value 16'h1111) -> ignored; the display shows the first loaded value after the boundary.
//  4. i_En low during digit 2 -> o_Dig=1111 and o_Seg=00 next cycle.
//     i_En high again -> digit 0 lit after 2 dark cycles.
//  5. Load 16'h00A0 -> digit 1 (value 10) shows 3f.
//     SEG7_LZB_EN build: load 16'h0007 -> only digit 0 lit (07); slots 1..3 dark, but the frame is still 40 cycles.
//  6. Assert i_Rst while digit 3 is lit with a load pending:
//     outputs go to reset values asynchronously; after release o_Ready=1 and the display shows 0 (3f) on all digits.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared types and constants for the 7-segment scan controller.
package seg7_pkg;

    typedef enum logic {
        S_GAP,
        S_SHOW
    } scan_state_t;

    localparam logic [6:0] SEG_OFF  = 7'h00;
    localparam logic [6:0] SEG_ZERO = 7'h3f;

    typedef logic [3:0] bcd_t;

endpackage

// File: rtl/seg7_scan_controller_decoder.sv
// Binary_To_7Segment: combinational BCD to {g,f,e,d,c,b,a} decoder, active-high segments.
module Binary_To_7Segment
    import seg7_pkg::*;
(
    input  bcd_t       i_Bcd,
    output logic [6:0] o_Seg
);

    always_comb begin
        // NOTE: assigning a default before the case keeps this purely combinational (no latch).
        o_Seg = SEG_ZERO;
        case (i_Bcd)
            4'd0:    o_Seg = 7'h3f;
            4'd1:    o_Seg = 7'h06;
            4'd2:    o_Seg = 7'h5b;
            4'd3:    o_Seg = 7'h4f;
            4'd4:    o_Seg = 7'h66;
            4'd5:    o_Seg = 7'h6d;
            4'd6:    o_Seg = 7'h7d;
            4'd7:    o_Seg = 7'h07;
            4'd8:    o_Seg = 7'h7f;
            4'd9:    o_Seg = 7'h6f;
            default: o_Seg = SEG_ZERO;
        endcase
    end

endmodule

// File: rtl/seg7_scan_controller.sv
// Multiplexed common-anode 7-segment scanner with double-buffered frame-boundary updates.
// Optional leading-zero blanking is enabled by defining SEG7_LZB_EN.
module seg7_scan_controller
    import seg7_pkg::*;
#(
    parameter int DIGITS = 4,
    parameter int DWELL  = 50000,
    parameter int GAP    = 16
) (
    input  logic                  i_Clk,
    input  logic                  i_Rst,
    input  logic                  i_En,
    input  logic                  i_Load,
    input  logic [4*DIGITS-1:0]   i_Digits,
    output logic                  o_Ready,
    output logic [6:0]            o_Seg,
    output logic [DIGITS-1:0]     o_Dig,
    output logic                  o_Frame
);

    localparam int CNT_MAX = (DWELL > GAP) ? DWELL : GAP;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam int IW      = $clog2(DIGITS);

    localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL - 1);
    localparam logic [CW-1:0] GAP_LAST   = CW'(GAP - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(DIGITS - 1);

    scan_state_t          state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [IW-1:0]        idx_q, idx_d;
    logic [4*DIGITS-1:0]  disp_q, disp_d;
    logic [4*DIGITS-1:0]  pend_q, pend_d;
    logic                 pend_valid_q, pend_valid_d;
    logic [6:0]           seg_q, seg_d;
    logic [DIGITS-1:0]    dig_q, dig_d;
    logic                 frame_q, frame_d;

    bcd_t                 dec_in;
    logic [6:0]           dec_seg;
    logic                 blank;
    logic                 lit;

`ifdef SEG7_LZB_EN
    // A digit is a leading zero when it and every digit above it are zero; digit 0 always shows.
    function automatic logic lead_zero(input logic [4*DIGITS-1:0] v, input logic [IW-1:0] idx);
        lead_zero = (idx != '0);
        for (int k = 0; k < DIGITS; k++) begin
            if (k >= int'(idx) && v[4*k +: 4] != 4'd0) lead_zero = 1'b0;
        end
    endfunction
`endif

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        idx_d        = idx_q;
        disp_d       = disp_q;
        pend_d       = pend_q;
        pend_valid_d = pend_valid_q;
        frame_d      = 1'b0;

        if (!i_En) begin
            state_d = S_GAP;
            cnt_d   = '0;
            idx_d   = '0;
            if (pend_valid_q) begin
                disp_d       = pend_q;
                pend_valid_d = 1'b0;
            end
        end else begin
            case (state_q)
                S_GAP: begin
                    if (cnt_q == GAP_LAST) begin
                        state_d = S_SHOW;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                S_SHOW: begin
                    if (cnt_q == DWELL_LAST) begin
                        state_d = S_GAP;
                        cnt_d   = '0;
                        if (idx_q == IDX_LAST) begin
                            idx_d   = '0;
                            frame_d = 1'b1;
                            if (pend_valid_q) begin
                                disp_d       = pend_q;
                                pend_valid_d = 1'b0;
                            end
                        end else begin
                            idx_d = idx_q + 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: state_d = S_GAP;
            endcase
        end

        // Load and swap are mutually exclusive: a load is only taken with the pending buffer empty.
        if (i_Load && !pend_valid_q) begin
            pend_d       = i_Digits;
            pend_valid_d = 1'b1;
        end
    end

    // Outputs are computed from the next state so they register on the same edge as the FSM.
    always_comb begin
        dec_in = disp_d[4*int'(idx_d) +: 4];
`ifdef SEG7_LZB_EN
        blank  = lead_zero(disp_d, idx_d);
`else
        blank  = 1'b0;
`endif
        lit    = (state_d == S_SHOW) && !blank;
        seg_d  = lit ? dec_seg : SEG_OFF;
        dig_d  = lit ? ~(DIGITS'(1) << idx_d) : '1;
    end

    Binary_To_7Segment u_dec (
        .i_Bcd (dec_in),
        .o_Seg (dec_seg)
    );

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            state_q      <= S_GAP;
            cnt_q        <= '0;
            idx_q        <= '0;
            // NOTE: both buffers are reset so the display is a defined "0" and any pending load is dropped.
            disp_q       <= '0;
            pend_q       <= '0;
            pend_valid_q <= 1'b0;
            seg_q        <= SEG_OFF;
            dig_q        <= '1;
            frame_q      <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the pre-edge values.
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            disp_q       <= disp_d;
            pend_q       <= pend_d;
            pend_valid_q <= pend_valid_d;
            seg_q        <= seg_d;
            dig_q        <= dig_d;
            frame_q      <= frame_d;
        end
    end

    assign o_Ready = ~pend_valid_q;
    assign o_Seg   = seg_q;
    assign o_Dig   = dig_q;
    assign o_Frame = frame_q;

endmodule

// File: tb/tb_seg7_scan_controller.sv
// Directed bench for seg7_scan_controller with a cycle-level timeline model (DIGITS=4, DWELL=8, GAP=2).
module tb_seg7_scan_controller;

    localparam int DIGITS = 4;
    localparam int DWELL  = 8;
    localparam int GAP    = 2;
    localparam int SLOT   = DWELL + GAP;
    localparam int FRAME  = DIGITS * SLOT;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 en;
    logic                 ld;
    logic [4*DIGITS-1:0]  digits;
    logic                 o_Ready;
    logic [6:0]           o_Seg;
    logic [DIGITS-1:0]    o_Dig;
    logic                 o_Frame;

    int total = 0;
    int bad   = 0;

    logic [6:0] seg_tab [16] = '{7'h3f, 7'h06, 7'h5b, 7'h4f, 7'h66, 7'h6d, 7'h7d, 7'h07,
                                 7'h7f, 7'h6f, 7'h3f, 7'h3f, 7'h3f, 7'h3f, 7'h3f, 7'h3f};

    seg7_scan_controller #(.DIGITS(DIGITS), .DWELL(DWELL), .GAP(GAP)) dut (
        .i_Clk    (clk),
        .i_Rst    (rst),
        .i_En     (en),
        .i_Load   (ld),
        .i_Digits (digits),
        .o_Ready  (o_Ready),
        .o_Seg    (o_Seg),
        .o_Dig    (o_Dig),
        .o_Frame  (o_Frame)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: k = cycles since the scan (re)started; slot and phase follow from plain arithmetic.
    int                  m_k;
    logic [4*DIGITS-1:0] m_disp, m_pend;
    bit                  m_pv;

    always @(posedge clk or posedge rst) begin
        bit old_pv;
        if (rst) begin
            m_k = 0; m_disp = '0; m_pend = '0; m_pv = 1'b0;
        end else begin
            old_pv = m_pv;
            if (!en) begin
                m_k = 0;
                if (old_pv) begin m_disp = m_pend; m_pv = 1'b0; end
            end else begin
                m_k = m_k + 1;
                if (m_k % FRAME == 0 && old_pv) begin m_disp = m_pend; m_pv = 1'b0; end
            end
            if (ld && !old_pv) begin m_pend = digits; m_pv = 1'b1; end
        end
    end

    always @(negedge clk) begin
        int  slot, off;
        bit  lit, blank;
        logic [DIGITS-1:0] e_dig;
        logic [6:0]        e_seg;
        if (!rst) begin
            slot  = (m_k / SLOT) % DIGITS;
            off   = m_k % SLOT;
            blank = 1'b0;
`ifdef SEG7_LZB_EN
            if (slot > 0) begin
                blank = 1'b1;
                for (int j = slot; j < DIGITS; j++)
                    if (m_disp[4*j +: 4] != 4'd0) blank = 1'b0;
            end
`endif
            lit   = (off >= GAP) && !blank;
            e_dig = lit ? ~(DIGITS'(1) << slot) : '1;
            e_seg = lit ? seg_tab[m_disp[4*slot +: 4]] : 7'h00;
            check("model_dig",   o_Dig,   e_dig);
            check("model_seg",   o_Seg,   e_seg);
            check("model_frame", o_Frame, (m_k > 0 && m_k % FRAME == 0));
            check("model_ready", o_Ready, !m_pv);
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic wait_frame(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!o_Frame && n < 200);
        check("frame_seen", o_Frame, 1);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_dig"},   o_Dig,   4'hf);
        check({tag, "_seg"},   o_Seg,   7'h00);
        check({tag, "_ready"}, o_Ready, 1);
        check({tag, "_frame"}, o_Frame, 0);
    endtask

    task automatic load(input logic [15:0] v);
        ld = 1'b1; digits = v;
        tick();
        ld = 1'b0;
    endtask

    initial begin
        int n;
        rst = 1'b0; en = 1'b0; ld = 1'b0; digits = '0;
        #1 rst = 1'b1;
        repeat (2) tick();
        check_reset_vals("reset");
        rst = 1'b0;
        tick();
        check("ready_after_reset", o_Ready, 1);

        // Scan order and segment patterns for 4321
        en = 1'b1;
        load(16'h4321);
        check("ready_low_after_load", o_Ready, 0);
        wait_frame(n);
        check("ready_after_boundary", o_Ready, 1);
        for (int i = 1; i <= FRAME; i++) begin
            tick();
            if (i == 1)  check("gap_dark", o_Dig, 4'b1111);
            if (i == 2)  begin check("d0_dig", o_Dig, 4'b1110); check("d0_seg", o_Seg, 7'h06); end
            if (i == 12) begin check("d1_dig", o_Dig, 4'b1101); check("d1_seg", o_Seg, 7'h5b); end
            if (i == 22) begin check("d2_dig", o_Dig, 4'b1011); check("d2_seg", o_Seg, 7'h4f); end
            if (i == 32) begin check("d3_dig", o_Dig, 4'b0111); check("d3_seg", o_Seg, 7'h66); end
            if (i == FRAME) check("frame_period", o_Frame, 1);
        end

        // Mid-frame load, then an ignored second load
        repeat (15) tick();
        load(16'h9999);
        check("ready_low_mid", o_Ready, 0);
        load(16'h1111);
        check("ready_still_low", o_Ready, 0);
        check("old_value_shown", o_Seg, 7'h5b);
        wait_frame(n);
        repeat (2) tick();
        check("new_d0_dig", o_Dig, 4'b1110);
        check("new_d0_seg", o_Seg, 7'h6f);

        // Enable drop during digit 2 and restart
        repeat (20) tick();
        check("pre_drop_dig", o_Dig, 4'b1011);
        en = 1'b0;
        tick();
        check("drop_dig", o_Dig, 4'b1111);
        check("drop_seg", o_Seg, 7'h00);
        en = 1'b1;
        tick();
        check("restart_gap", o_Dig, 4'b1111);
        tick();
        check("restart_d0_dig", o_Dig, 4'b1110);
        check("restart_d0_seg", o_Seg, 7'h6f);

        // Out-of-range digit decodes as zero
        load(16'h00A0);
        wait_frame(n);
        wait_frame(n);
        check("frame_len", n, FRAME);
        repeat (12) tick();
        check("a_dig", o_Dig, 4'b1101);
        check("a_seg", o_Seg, 7'h3f);
`ifdef SEG7_LZB_EN
        load(16'h0007);
        wait_frame(n);
        wait_frame(n);
        check("lzb_frame_len", n, FRAME);
        repeat (2) tick();
        check("lzb_d0_dig", o_Dig, 4'b1110);
        check("lzb_d0_seg", o_Seg, 7'h07);
        repeat (10) tick();
        check("lzb_d1_dig", o_Dig, 4'b1111);
        check("lzb_d1_seg", o_Seg, 7'h00);
`endif

        // Asynchronous reset with a load pending
        wait_frame(n);
        repeat (32) tick();
        check("pre_rst_d3", o_Dig, 4'b0111);
        load(16'h5555);
        check("pending_before_rst", o_Ready, 0);
        #2 rst = 1'b1;
        #1 check_reset_vals("async_rst");
        tick();
        rst = 1'b0;
        wait_frame(n);
        repeat (2) tick();
        check("post_rst_ready", o_Ready, 1);
        check("post_rst_dig", o_Dig, 4'b1110);
        check("post_rst_seg", o_Seg, 7'h3f);
        wait_frame(n);
        repeat (2) tick();
        check("discarded_load_seg", o_Seg, 7'h3f);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
